// File: rtl/cdc_pulse_queue_sender.sv
// Source-domain sender for the toggle req/ack pulse crossing. Events that arrive
// while a transfer is in flight are queued in a saturating counter and launched back to back.
module cdc_pulse_queue_sender #(
    parameter int SYNC_DEPTH = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_pulse,
    input  logic                 i_clear_overflow,
    output logic                 o_async_req,
    input  logic                 i_async_ack,
    output logic [CNT_WIDTH-1:0] o_pending,
    output logic                 o_busy,
    output logic                 o_overflow
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PENDING_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] PENDING_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] PENDING_ONE  = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic                   req;
    logic                   req_next;
    logic [CNT_WIDTH-1:0]   pending;
    logic [CNT_WIDTH-1:0]   pending_next;
    logic                   overflow;
    logic                   overflow_next;
    logic                   overflow_set;
    logic                   synced_ack;

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [SYNC_DEPTH-1:0] ack_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_DEPTH-2:0], i_async_ack};
        end
    end

    assign synced_ack = ack_sync[SYNC_DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req      <= 1'b0;
            pending  <= PENDING_ZERO;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            req      <= req_next;
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

    // A launch consumes one event; a pulse in the same cycle replaces it, so the count holds.
    always_comb begin
        state_next   = state;
        req_next     = req;
        pending_next = pending;
        overflow_set = 1'b0;

        case (state)
            IDLE: begin
                if ((pending != PENDING_ZERO) || i_pulse) begin
                    req_next   = ~req;
                    state_next = WAIT_ACK;
                    if (!i_pulse) begin
                        pending_next = pending - PENDING_ONE;
                    end
                end
            end
            WAIT_ACK: begin
                if (synced_ack == req) begin
                    state_next = IDLE;
                end
                if (i_pulse) begin
                    if (pending == PENDING_MAX) begin
                        overflow_set = 1'b1;
                    end else begin
                        pending_next = pending + PENDING_ONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (overflow_set) begin
            overflow_next = 1'b1;
        end else if (i_clear_overflow) begin
            overflow_next = 1'b0;
        end else begin
            overflow_next = overflow;
        end
    end

    assign o_async_req = req;
    assign o_pending   = pending;
    assign o_overflow  = overflow;
    assign o_busy      = (state == WAIT_ACK) || (pending != PENDING_ZERO);

endmodule
